alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter BCD_EN, default 1, meaning 1 = decimal-adjust passes enabled; 0 = req_bcd ignored and treated as 0.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  sequencer accepts request; high only in IDLE.
REQ-006 req_op  input  3  ALU control code (ADD, AND from shared params; others illegal).
REQ-007 req_a, req_b  input  8 each  operands.
REQ-008 req_carry  input  1  carry in (P.C).
REQ-009 req_bcd  input  1  decimal mode (P.D).
REQ-010 req_flags  input  8  current processor status, captured at accept.
REQ-011 alu_ctrl  output  3; alu_AI, alu_BI  output  8 each; alu_carry, alu_BCD  output  1 each  drive to ALU.
REQ-012 alu_Y  input  8; alu_flags  input  8  combinational ALU results.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  consumer accepts result.
REQ-015 rsp_y  output  8; rsp_flags  output  8; rsp_illegal  output  1  result, updated status, unsupported-op marker.

Function
REQ-016 States SHALL be IDLE, EXEC, ADJ_LO, ADJ_HI, RESP; encoding free.
REQ-017 Accept = req_valid & req_ready in IDLE; operands, op, carry, bcd, flags SHALL be registered on accept; IDLE -> EXEC.
REQ-018 EXEC: drive alu_ctrl=op, AI=a, BI=b, alu_carry=carry, alu_BCD=0 always; register alu_Y and alu_flags[CARRY].
REQ-019 EXEC -> ADJ_LO if op==ADD and decimal active, else -> RESP.
REQ-020 ADJ_LO: ALU ADD, AI=pass-1 result, BI=0x06 if (a[3:0]+b[3:0]+carry)>9 else 0x00, carry 0; register result, OR ALU carry into C.
REQ-021 ADJ_HI: ALU ADD, AI=ADJ_LO result, BI=0x60 if result[7:4]>9 or accumulated C==1 else 0x00, carry 0; register result, C |= ALU carry or (BI==0x60).
REQ-022 Latency fixed: accept in cycle N -> rsp_valid cycle N+2 (binary/AND/illegal), N+4 (decimal ADD, both passes always run).
REQ-023 ADD flags: N=result[7], Z=(result==0), C per REQ-018/021, V=(a[7]==b[7])&(pass-1 result[7]!=a[7]); other bits from req_flags.
REQ-024 AND flags: N, Z from result; C, V and others unchanged from req_flags.
REQ-025 Illegal op: rsp_y=req_a, rsp_flags=req_flags, rsp_illegal=1; binary latency.
REQ-026 RESP: rsp_valid=1, rsp_* stable until rsp_ready; RESP -> IDLE on rsp_ready; no new request accepted in same cycle.
REQ-027 When not in EXEC/ADJ_*, ALU drive outputs SHALL be 0.
REQ-028 Result/flag registers are 8-bit; carry out of bit 7 never widens outputs.

Reset
REQ-029 reset SHALL force IDLE immediately from any state, including mid-sequence or stalled RESP; pending operation discarded.
REQ-030 Reset values: req_ready=1 after deassert (0 during reset), rsp_valid=0, rsp_y=0, rsp_flags=0, rsp_illegal=0, all alu_* outputs 0.

Structure
REQ-031 Op codes (ADD, AND) and flag indices (CARRY, ZERO, OVFL, NEG) SHALL come from the shared params include; state encoding local.
REQ-032 Sequencer contains no arithmetic adder for results; all sums go through the alu instance, instantiated once in the testbench/top, not inside.
REQ-033 Nibble-compare logic may be a local function; no sub-module required.

Verification
REQ-034 Binary ADD 0x7F+0x01, C=0, D=0 -> rsp_y=0x80, N=1 V=1 Z=0 C=0, rsp_valid at N+2.
REQ-035 Decimal ADD 0x45+0x38, C=0, D=1 -> rsp_y=0x83, C=0, rsp_valid at N+4.
REQ-036 Decimal ADD 0x99+0x01, C=0, D=1 -> rsp_y=0x00, C=1, Z=1.
REQ-037 AND 0xF0&0x0F, req_flags C=1 -> rsp_y=0x00, Z=1, N=0, C=1 preserved.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0; release -> IDLE next cycle.
REQ-039 reset asserted during ADJ_LO -> rsp_valid=0, outputs 0 asynchronously; next request completes correctly.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared ALU op codes, status flag bit positions and flag-merge helpers.
// Pure definitions: no latency, no backpressure.
package alu_sequencer_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_OVFL  = 6;
    localparam int FLAG_NEG   = 7;

    function automatic logic [7:0] add_flags(input logic [7:0] base, input logic [7:0] y,
                                             input logic c, input logic v);
        logic [7:0] f;
        f             = base;
        f[FLAG_NEG]   = y[7];
        f[FLAG_ZERO]  = (y == 8'h00);
        f[FLAG_CARRY] = c;
        f[FLAG_OVFL]  = v;
        return f;
    endfunction

    function automatic logic [7:0] logic_flags(input logic [7:0] base, input logic [7:0] y);
        logic [7:0] f;
        f            = base;
        f[FLAG_NEG]  = y[7];
        f[FLAG_ZERO] = (y == 8'h00);
        return f;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequences an external ALU through a binary pass and optional decimal-adjust passes; result in 2 cycles (4 for decimal ADD).
// One request in flight; req_ready only in IDLE, result held in RESP until rsp_ready.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int BCD_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_carry,
    input  logic       req_bcd,
    input  logic [7:0] req_flags,
    output logic [2:0] alu_ctrl,
    output logic [7:0] alu_AI,
    output logic [7:0] alu_BI,
    output logic       alu_carry,
    output logic       alu_BCD,
    input  logic [7:0] alu_Y,
    input  logic [7:0] alu_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic [7:0] rsp_flags,
    output logic       rsp_illegal
);

    typedef enum logic [2:0] {ST_IDLE, ST_EXEC, ST_ADJ_LO, ST_ADJ_HI, ST_RESP} state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] a_q, a_d, b_q, b_d, flags_q, flags_d, res_q, res_d;
    logic       carry_q, carry_d, bcd_q, bcd_d, c_q, c_d, v_q, v_d;
    logic [7:0] rsp_y_q, rsp_y_d, rsp_flags_q, rsp_flags_d;
    logic       rsp_illegal_q, rsp_illegal_d;
    logic       hi_adj;

    // Only the ALU carry-out feeds the sequence; other ALU flags are recomputed here.
    logic unused_alu_flags;
    assign unused_alu_flags = ^alu_flags[7:1];

    function automatic logic lo_adj(input logic [3:0] a, input logic [3:0] b, input logic c);
        return ({1'b0, a} + {1'b0, b} + {4'b0000, c}) > 5'd9;
    endfunction

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        carry_d       = carry_q;
        bcd_d         = bcd_q;
        flags_d       = flags_q;
        res_d         = res_q;
        c_d           = c_q;
        v_d           = v_q;
        rsp_y_d       = rsp_y_q;
        rsp_flags_d   = rsp_flags_q;
        rsp_illegal_d = rsp_illegal_q;
        alu_ctrl      = 3'd0;
        alu_AI        = 8'h00;
        alu_BI        = 8'h00;
        alu_carry     = 1'b0;
        alu_BCD       = 1'b0;
        hi_adj        = (res_q[7:4] > 4'd9) || c_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    carry_d = req_carry;
                    bcd_d   = req_bcd && (BCD_EN != 0);
                    flags_d = req_flags;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_ctrl  = op_q;
                alu_AI    = a_q;
                alu_BI    = b_q;
                alu_carry = carry_q;
                res_d     = alu_Y;
                c_d       = alu_flags[FLAG_CARRY];
                v_d       = (a_q[7] == b_q[7]) && (alu_Y[7] != a_q[7]);
                if (op_q == OP_ADD && bcd_q) begin
                    state_d = ST_ADJ_LO;
                end else begin
                    state_d       = ST_RESP;
                    rsp_illegal_d = 1'b0;
                    rsp_y_d       = alu_Y;
                    if (op_q == OP_ADD) begin
                        rsp_flags_d = add_flags(flags_q, alu_Y, c_d, v_d);
                    end else if (op_q == OP_AND) begin
                        rsp_flags_d = logic_flags(flags_q, alu_Y);
                    end else begin
                        rsp_y_d       = a_q;
                        rsp_flags_d   = flags_q;
                        rsp_illegal_d = 1'b1;
                    end
                end
            end
            ST_ADJ_LO: begin
                alu_ctrl = OP_ADD;
                alu_AI   = res_q;
                alu_BI   = lo_adj(a_q[3:0], b_q[3:0], carry_q) ? 8'h06 : 8'h00;
                res_d    = alu_Y;
                c_d      = c_q | alu_flags[FLAG_CARRY];
                state_d  = ST_ADJ_HI;
            end
            ST_ADJ_HI: begin
                alu_ctrl      = OP_ADD;
                alu_AI        = res_q;
                alu_BI        = hi_adj ? 8'h60 : 8'h00;
                res_d         = alu_Y;
                // Adding 0x60 is itself the decimal carry out, even when the ALU sum does not wrap.
                c_d           = c_q | alu_flags[FLAG_CARRY] | hi_adj;
                rsp_y_d       = alu_Y;
                rsp_flags_d   = add_flags(flags_q, alu_Y, c_d, v_q);
                rsp_illegal_d = 1'b0;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= 3'd0;
            a_q           <= 8'h00;
            b_q           <= 8'h00;
            carry_q       <= 1'b0;
            bcd_q         <= 1'b0;
            flags_q       <= 8'h00;
            res_q         <= 8'h00;
            c_q           <= 1'b0;
            v_q           <= 1'b0;
            rsp_y_q       <= 8'h00;
            rsp_flags_q   <= 8'h00;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            carry_q       <= carry_d;
            bcd_q         <= bcd_d;
            flags_q       <= flags_d;
            res_q         <= res_d;
            c_q           <= c_d;
            v_q           <= v_d;
            rsp_y_q       <= rsp_y_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE) && !reset;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_y       = rsp_y_q;
    assign rsp_flags   = rsp_flags_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU closing the loop.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = 3'd0;
    logic [7:0] req_a = 8'h00, req_b = 8'h00, req_flags = 8'h00;
    logic       req_carry = 1'b0, req_bcd = 1'b0;
    logic [2:0] alu_ctrl;
    logic [7:0] alu_AI, alu_BI, alu_Y, alu_flags;
    logic       alu_carry, alu_BCD;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_y, rsp_flags;
    logic       rsp_illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.BCD_EN(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_carry(req_carry), .req_bcd(req_bcd),
        .req_flags(req_flags),
        .alu_ctrl(alu_ctrl), .alu_AI(alu_AI), .alu_BI(alu_BI),
        .alu_carry(alu_carry), .alu_BCD(alu_BCD),
        .alu_Y(alu_Y), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal)
    );

    logic [8:0] alu_sum;
    always_comb begin
        alu_sum   = 9'd0;
        alu_Y     = 8'h00;
        alu_flags = 8'h00;
        case (alu_ctrl)
            OP_ADD: begin
                alu_sum = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'd0, alu_carry};
                alu_Y   = alu_sum[7:0];
                alu_flags[FLAG_CARRY] = alu_sum[8];
            end
            OP_AND:  alu_Y = alu_AI & alu_BI;
            default: alu_Y = 8'h00;
        endcase
        alu_flags[FLAG_ZERO] = (alu_Y == 8'h00);
        alu_flags[FLAG_NEG]  = alu_Y[7];
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic d, input logic [7:0] f, output int lat);
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_carry = c; req_bcd = d; req_flags = f;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready_low got %b want 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready_high got %b want 1", req_ready); end
        n_cmp++; if ({rsp_y, rsp_flags, rsp_illegal} !== 17'h0) begin n_fail++; $display("FAIL reset_rsp_zero got %h want 0", {rsp_y, rsp_flags, rsp_illegal}); end
        n_cmp++; if ({alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD} !== 21'h0) begin n_fail++; $display("FAIL reset_alu_zero got %h want 0", {alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD}); end
    endtask

    task automatic test_binary_add();
        int lat;
        issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h20, lat);
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL bin_add_latency got %0d want 2", lat); end
        n_cmp++; if (rsp_y !== 8'h80) begin n_fail++; $display("FAIL bin_add_y got %h want 80", rsp_y); end
        n_cmp++; if (rsp_flags !== 8'hE0) begin n_fail++; $display("FAIL bin_add_flags got %h want e0", rsp_flags); end
        n_cmp++; if (rsp_illegal !== 1'b0) begin n_fail++; $display("FAIL bin_add_illegal got %b want 0", rsp_illegal); end
        release_rsp();
        issue(OP_ADD, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, lat);
        n_cmp++; if (rsp_y !== 8'h00) begin n_fail++; $display("FAIL bin_add_wrap_y got %h want 00", rsp_y); end
        n_cmp++; if (rsp_flags !== 8'h03) begin n_fail++; $display("FAIL bin_add_wrap_flags got %h want 03", rsp_flags); end
        release_rsp();
    endtask

    task automatic test_alu_drive();
        @(negedge clk);
        req_op = OP_ADD; req_a = 8'h3C; req_b = 8'hA5; req_carry = 1'b1; req_bcd = 1'b0; req_flags = 8'h00;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if ({alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD} !== {OP_ADD, 8'h3C, 8'hA5, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL exec_alu_drive got %h want %h", {alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD}, {OP_ADD, 8'h3C, 8'hA5, 1'b1, 1'b0});
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rsp_y !== 8'hE2 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL exec_result got %h/%b want e2/1", rsp_y, rsp_valid); end
        n_cmp++; if ({alu_ctrl, alu_AI, alu_BI} !== 19'h0) begin n_fail++; $display("FAIL resp_alu_idle got %h want 0", {alu_ctrl, alu_AI, alu_BI}); end
        release_rsp();
    endtask

    task automatic test_decimal_add();
        int lat;
        issue(OP_ADD, 8'h45, 8'h38, 1'b0, 1'b1, 8'h28, lat);
        n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL dec_add_latency got %0d want 4", lat); end
        n_cmp++; if (rsp_y !== 8'h83) begin n_fail++; $display("FAIL dec_add_y got %h want 83", rsp_y); end
        n_cmp++; if (rsp_flags !== 8'hA8) begin n_fail++; $display("FAIL dec_add_flags got %h want a8", rsp_flags); end
        release_rsp();
        issue(OP_ADD, 8'h99, 8'h01, 1'b0, 1'b1, 8'h28, lat);
        n_cmp++; if (rsp_y !== 8'h00) begin n_fail++; $display("FAIL dec_wrap_y got %h want 00", rsp_y); end
        n_cmp++; if (rsp_flags !== 8'h2B) begin n_fail++; $display("FAIL dec_wrap_flags got %h want 2b", rsp_flags); end
        release_rsp();
        issue(OP_ADD, 8'h09, 8'h00, 1'b1, 1'b1, 8'h08, lat);
        n_cmp++; if (rsp_y !== 8'h10 || rsp_flags !== 8'h08) begin n_fail++; $display("FAIL dec_carry_in got %h/%h want 10/08", rsp_y, rsp_flags); end
        n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL dec_carry_in_latency got %0d want 4", lat); end
        release_rsp();
    endtask

    task automatic test_and_op();
        int lat;
        issue(OP_AND, 8'hF0, 8'h0F, 1'b0, 1'b1, 8'h61, lat);
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL and_latency got %0d want 2", lat); end
        n_cmp++; if (rsp_y !== 8'h00) begin n_fail++; $display("FAIL and_y got %h want 00", rsp_y); end
        n_cmp++; if (rsp_flags !== 8'h63) begin n_fail++; $display("FAIL and_flags got %h want 63", rsp_flags); end
        release_rsp();
        issue(OP_AND, 8'hC3, 8'hA5, 1'b1, 1'b0, 8'h00, lat);
        n_cmp++; if (rsp_y !== 8'h81 || rsp_flags !== 8'h80) begin n_fail++; $display("FAIL and_neg got %h/%h want 81/80", rsp_y, rsp_flags); end
        release_rsp();
    endtask

    task automatic test_illegal();
        int lat;
        issue(3'd5, 8'h12, 8'h34, 1'b1, 1'b1, 8'h55, lat);
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL illegal_latency got %0d want 2", lat); end
        n_cmp++; if ({rsp_y, rsp_flags, rsp_illegal} !== {8'h12, 8'h55, 1'b1}) begin
            n_fail++; $display("FAIL illegal_rsp got %h want %h", {rsp_y, rsp_flags, rsp_illegal}, {8'h12, 8'h55, 1'b1});
        end
        release_rsp();
        issue(OP_ADD, 8'h01, 8'h01, 1'b0, 1'b0, 8'h00, lat);
        n_cmp++; if (rsp_illegal !== 1'b0 || rsp_y !== 8'h02) begin n_fail++; $display("FAIL illegal_cleared got %b/%h want 0/02", rsp_illegal, rsp_y); end
        release_rsp();
    endtask

    task automatic test_backpressure();
        int lat;
        issue(OP_ADD, 8'h10, 8'h20, 1'b0, 1'b0, 8'h00, lat);
        req_op = OP_AND; req_a = 8'hFF; req_b = 8'hFF; req_bcd = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if ({rsp_valid, req_ready, rsp_y, rsp_flags} !== {1'b1, 1'b0, 8'h30, 8'h00}) begin
                n_fail++; $display("FAIL stall_hold[%0d] got %h want %h", i, {rsp_valid, req_ready, rsp_y, rsp_flags}, {1'b1, 1'b0, 8'h30, 8'h00});
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b/%b want 0/1", rsp_valid, req_ready); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL no_accept_on_release got %b want 1", req_ready); end
    endtask

    task automatic test_reset_mid_seq();
        int lat;
        @(negedge clk);
        req_op = OP_ADD; req_a = 8'h45; req_b = 8'h38; req_carry = 1'b0; req_bcd = 1'b1; req_flags = 8'h00;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (alu_AI !== 8'h7D || alu_BI !== 8'h06) begin n_fail++; $display("FAIL adj_lo_drive got %h/%h want 7d/06", alu_AI, alu_BI); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({rsp_valid, req_ready, alu_ctrl, alu_AI, alu_BI, alu_carry} !== 22'h0) begin
            n_fail++; $display("FAIL reset_async got %h want 0", {rsp_valid, req_ready, alu_ctrl, alu_AI, alu_BI, alu_carry});
        end
        n_cmp++; if ({rsp_y, rsp_flags} !== 16'h0) begin n_fail++; $display("FAIL reset_async_rsp got %h want 0", {rsp_y, rsp_flags}); end
        @(negedge clk);
        reset = 1'b0;
        issue(OP_ADD, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, lat);
        n_cmp++; if (lat != 4 || rsp_y !== 8'h00 || rsp_flags !== 8'h03) begin
            n_fail++; $display("FAIL post_reset_op got lat %0d y %h f %h want 4/00/03", lat, rsp_y, rsp_flags);
        end
        release_rsp();
    endtask

    initial begin
        test_reset();
        test_binary_add();
        test_alu_drive();
        test_decimal_add();
        test_and_op();
        test_illegal();
        test_backpressure();
        test_reset_mid_seq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
